sa_core_ctrl: RTL and testbench

Sequencing controller for the systolic array core. It accepts one tile of operand vectors from an upstream buffer and applies the diagonal row skew. It drives the core's `inpvalid` and operand lanes, waits for all row results, then streams the results out one row at a time. After the last row it pulses the core's `outread`. It sits between the operand/result buffers and `SA_CORE`; one instance per core.

---
 rtl/sa_core_ctrl.sv | 149 ++++++++++++++
 tb/tb_sa_core_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sa_core_ctrl.sv
// Tile sequencer for one systolic array core: feeds diagonally skewed operand lanes,
// waits for every row result, streams rows out under valid/ready, then acknowledges the core.
module sa_core_ctrl #(
  parameter int ROWS = 8,
  parameter int DW   = 8,
  parameter int RW   = 32,
  parameter int KW   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KW-1:0]            k_len,
  output logic                     busy,
  output logic                     done,
  input  logic [ROWS*DW-1:0]       src_a,
  input  logic [ROWS*DW-1:0]       src_w,
  input  logic                     src_valid,
  output logic                     src_ready,
  output logic [ROWS*DW-1:0]       core_a,
  output logic [ROWS*DW-1:0]       core_w,
  output logic                     core_inpvalid,
  output logic                     core_outread,
  input  logic [ROWS-1:0]          core_rvalid,
  input  logic [ROWS*RW-1:0]       core_rdata,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RW-1:0]            res_data,
  output logic [$clog2(ROWS)-1:0]  res_row
);
  localparam int RIW = $clog2(ROWS);

  typedef enum logic [2:0] {IDLE, FEED, SKEW, DRAIN, READ, FIN} state_t;

  state_t          state, nxt;
  logic [KW-1:0]   klen_q;
  logic [KW-1:0]   beat_cnt;
  logic [RIW-1:0]  skew_cnt;
  logic [RIW-1:0]  row_idx;
  logic            zero_q;
  logic            feed;
  logic            adv;

  assign feed = (state == FEED);
  // Pipeline only moves on accepted beats or while flushing zeros through the skew.
  assign adv  = (feed && src_valid) || (state == SKEW);

  always_comb begin
    nxt          = state;
    busy         = (state != IDLE);
    done         = 1'b0;
    src_ready    = 1'b0;
    core_outread = 1'b0;
    res_valid    = 1'b0;
    res_row      = '0;
    res_data     = '0;
    case (state)
      IDLE:  if (start) nxt = (k_len == '0) ? FIN : FEED;
      FEED: begin
        src_ready = 1'b1;
        if (src_valid && beat_cnt == klen_q - KW'(1)) nxt = (ROWS == 1) ? DRAIN : SKEW;
      end
      SKEW:  if (skew_cnt == RIW'(ROWS - 2)) nxt = DRAIN;
      DRAIN: if (&core_rvalid) nxt = READ;
      READ: begin
        res_valid = 1'b1;
        res_row   = row_idx;
        res_data  = core_rdata[RW*row_idx +: RW];
        if (res_ready && row_idx == RIW'(ROWS - 1)) nxt = FIN;
      end
      FIN: begin
        done         = 1'b1;
        core_outread = !zero_q;
        nxt          = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      klen_q        <= '0;
      zero_q        <= 1'b0;
      beat_cnt      <= '0;
      skew_cnt      <= '0;
      row_idx       <= '0;
      core_inpvalid <= 1'b0;
    end else begin
      state         <= nxt;
      core_inpvalid <= adv;
      if (state == IDLE && start) begin
        klen_q   <= k_len;
        zero_q   <= (k_len == '0);
        beat_cnt <= '0;
      end else if (feed && src_valid) begin
        beat_cnt <= beat_cnt + KW'(1);
      end
      if (state == SKEW) skew_cnt <= skew_cnt + RIW'(1);
      else               skew_cnt <= '0;
      if (state == DRAIN)                 row_idx <= '0;
      else if (state == READ && res_ready) row_idx <= row_idx + RIW'(1);
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DW-1:0] a_q, w_q;
    assign core_a[r*DW +: DW] = a_q;
    assign core_w[r*DW +: DW] = w_q;

    if (r == 0) begin : g_direct
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          w_q <= '0;
        end else if (adv) begin
          a_q <= feed ? src_a[0 +: DW] : '0;
          w_q <= feed ? src_w[0 +: DW] : '0;
        end
      end
    end else begin : g_delay
      // r-deep delay line per lane produces the diagonal wavefront the array expects.
      logic [DW-1:0] da [r];
      logic [DW-1:0] dw [r];
      logic          dv [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < r; j++) begin
            da[j] <= '0;
            dw[j] <= '0;
            dv[j] <= 1'b0;
          end
          a_q <= '0;
          w_q <= '0;
        end else if (adv) begin
          da[0] <= feed ? src_a[r*DW +: DW] : '0;
          dw[0] <= feed ? src_w[r*DW +: DW] : '0;
          dv[0] <= feed;
          for (int j = 1; j < r; j++) begin
            da[j] <= da[j-1];
            dw[j] <= dw[j-1];
            dv[j] <= dv[j-1];
          end
          a_q <= dv[r-1] ? da[r-1] : '0;
          w_q <= dv[r-1] ? dw[r-1] : '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sa_core_ctrl.sv
// Directed bench for sa_core_ctrl: phase model predicts lane contents and handshakes,
// result rows are checked against a queue filled when each tile is started.
module tb_sa_core_ctrl;
  localparam int ROWS = 8;
  localparam int DW   = 8;
  localparam int RW   = 32;
  localparam int KW   = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [KW-1:0]           k_len;
  logic                    busy, done;
  logic [ROWS*DW-1:0]      src_a, src_w;
  logic                    src_valid, src_ready;
  logic [ROWS*DW-1:0]      core_a, core_w;
  logic                    core_inpvalid, core_outread;
  logic [ROWS-1:0]         core_rvalid;
  logic [ROWS*RW-1:0]      core_rdata;
  logic                    res_valid, res_ready;
  logic [RW-1:0]           res_data;
  logic [$clog2(ROWS)-1:0] res_row;

  int checks = 0;
  int errors = 0;
  int sb[$];

  sa_core_ctrl #(.ROWS(ROWS), .DW(DW), .RW(RW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .src_a(src_a), .src_w(src_w), .src_valid(src_valid), .src_ready(src_ready),
    .core_a(core_a), .core_w(core_w), .core_inpvalid(core_inpvalid),
    .core_outread(core_outread), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane r of beat idx carries a lane tag so misrouted lanes are visible.
  function automatic logic [7:0] beat_byte(int idx, int r, bit is_w);
    return is_w ? 8'(128 + idx*8 + r) : 8'(r*16 + idx);
  endfunction

  function automatic logic [63:0] beat_vec(int idx, bit is_w);
    logic [63:0] v = '0;
    for (int r = 0; r < ROWS; r++) v[r*8 +: 8] = beat_byte(idx, r, is_w);
    return v;
  endfunction

  function automatic logic [63:0] lanes_after(int n, int k, bit is_w);
    logic [63:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      if (n - r >= 1 && n - r <= k) v[r*8 +: 8] = beat_byte(n - r, r, is_w);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_src_ready"}, src_ready, 0);
    chk({tag, "_inpvalid"}, core_inpvalid, 0);
    chk({tag, "_outread"}, core_outread, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_core_a"}, core_a, 0);
    chk({tag, "_core_w"}, core_w, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_row"}, res_row, 0);
  endtask

  // ph: 0 feed, 1 skew, 2 drain, 3 read, 4 fin
  task automatic run_tile(input int k, input int stall_at, input int stall_n, input bit tog,
                          input int drain_hold, input bit start_mid, input bit abort_skew);
    int ph, n, acc, skw, row, left, hold, ivcnt;
    bit adv, rdy_t, mid_done;
    if (k != 0) for (int r = 0; r < ROWS; r++) sb.push_back(100 + r);
    start = 1'b1;
    k_len = KW'(k);
    core_rvalid = (drain_hold > 0) ? 8'h7F : 8'hFF;
    src_a = beat_vec(1, 0);
    src_w = beat_vec(1, 1);
    tick();
    start = 1'b0;
    ph = (k == 0) ? 4 : 0;
    n = 0; acc = 0; skw = 0; row = 0; left = stall_n; hold = drain_hold;
    ivcnt = 0; adv = 1'b0; rdy_t = 1'b1; mid_done = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk("busy", busy, 1);
      chk("inpvalid", core_inpvalid, adv);
      if (core_inpvalid) ivcnt++;
      if (n > 0) begin
        chk("core_a", core_a, lanes_after(n, k, 0));
        chk("core_w", core_w, lanes_after(n, k, 1));
      end
      chk("src_ready", src_ready, ph == 0);
      chk("res_valid", res_valid, ph == 3);
      chk("done", done, ph == 4);
      chk("outread", core_outread, ph == 4 && k != 0);
      if (ph == 3) begin
        chk("res_row", res_row, row);
        chk("res_data", res_data, sb[0]);
      end
      if (abort_skew && ph == 1) begin
        src_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        sb.delete();
        tick();
        rst = 1'b0;
        repeat (3) begin
          tick();
          chk("rst_no_done", done, 0);
          chk("rst_idle", busy, 0);
        end
        return;
      end
      if (ph == 4) begin
        tick();
        chk("fin_busy_drop", busy, 0);
        chk("fin_done_pulse", done, 0);
        chk("inpvalid_count", ivcnt, (k == 0) ? 0 : k + ROWS - 1);
        return;
      end
      // drive inputs for the coming edge and predict its effect
      src_valid = (ph == 0) && !(acc == stall_at && left > 0);
      if (ph == 0 && acc == stall_at && left > 0) left--;
      src_a = beat_vec(acc + 1, 0);
      src_w = beat_vec(acc + 1, 1);
      start = start_mid && !mid_done && ph == 0 && acc == 1;
      k_len = start ? KW'(9) : KW'(k);
      if (start) mid_done = 1'b1;
      res_ready = (ph == 3) ? (tog ? rdy_t : 1'b1) : 1'b0;
      if (ph == 3) rdy_t = !rdy_t;
      adv = (ph == 0 && src_valid) || ph == 1;
      case (ph)
        0: if (src_valid) begin
             acc++; n++;
             if (acc == k) ph = 1;
           end
        1: begin
             n++; skw++;
             if (skw == ROWS - 1) ph = 2;
           end
        2: if (hold > 0) begin
             hold--;
             core_rvalid = 8'h7F;
           end else begin
             core_rvalid = 8'hFF;
             ph = 3;
           end
        3: if (res_ready) begin
             void'(sb.pop_front());
             row++;
             if (row == ROWS) ph = 4;
           end
        default: ;
      endcase
      tick();
    end
    checks++;
    errors++;
    $error("FAIL tile_timeout observed=phase%0d expected=completion", ph);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; src_a = '0; src_w = '0; src_valid = 1'b0;
    res_ready = 1'b0; core_rvalid = '0;
    for (int r = 0; r < ROWS; r++) core_rdata[r*RW +: RW] = RW'(100 + r);
    #3 check_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_tile(4, -1, 0, 0, 0, 0, 0);   // basic tile
    run_tile(4, 2, 2, 0, 0, 0, 0);    // two stall cycles after beat 2
    run_tile(4, -1, 0, 1, 0, 0, 0);   // result backpressure 1,0,1,0
    run_tile(3, -1, 0, 0, 0, 1, 0);   // start raised during FEED is ignored
    run_tile(0, -1, 0, 0, 0, 0, 0);   // empty tile
    run_tile(4, -1, 0, 0, 0, 0, 1);   // reset during SKEW
    run_tile(2, -1, 0, 0, 0, 0, 0);   // clean tile after reset
    run_tile(2, -1, 0, 0, 20, 0, 0);  // DRAIN waits on partial rvalid
    run_tile(255, -1, 0, 0, 0, 0, 0); // maximum reduction length
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
